// File: rtl/dual_signal_meter_if.sv
// Result bus of the dual signal meter: window buffers, phase result and their update strobes.
// The meter drives it through the master modport; the reporting logic reads it through slave.
interface dual_signal_meter_if;
    logic [31:0] sig_freq_cnt_buf0;
    logic [31:0] sig_freq_cnt_buf1;
    logic [31:0] phase_diff_cnt_buf;
    logic [31:0] sig_in_high_cnt_buf;
    logic [31:0] sig_in_low_cnt_buf;
    logic        meas_valid;
    logic        phase_valid;

    modport master (
        output sig_freq_cnt_buf0,
        output sig_freq_cnt_buf1,
        output phase_diff_cnt_buf,
        output sig_in_high_cnt_buf,
        output sig_in_low_cnt_buf,
        output meas_valid,
        output phase_valid
    );

    modport slave (
        input sig_freq_cnt_buf0,
        input sig_freq_cnt_buf1,
        input phase_diff_cnt_buf,
        input sig_in_high_cnt_buf,
        input sig_in_low_cnt_buf,
        input meas_valid,
        input phase_valid
    );
endinterface

// File: rtl/dual_signal_meter.sv
// Gate-windowed frequency and duty-cycle meter for two async inputs, plus an
// event-driven rise0-to-rise1 phase delay measurement. All counters saturate.
module dual_signal_meter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       sig_in0,
    input  logic                       sig_in1,
    dual_signal_meter_if.master        res_o
);

    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;
    localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_MEAS = 1'b1
    } ph_state_e;

    function automatic logic [31:0] sat_add1(input logic [31:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + 32'd1;
        end
        return v;
    endfunction

    logic [SYNC_STAGES-1:0] sync0_q, sync0_d;
    logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
    logic                   dly0_q, dly1_q;
    logic                   lvl0, lvl1;
    logic                   rise0, rise1;

    logic [31:0] gate_cnt_q, gate_cnt_d;
    logic        win_end;

    logic [31:0] f0_run_q, f0_run_d, f0_buf_q, f0_buf_d;
    logic [31:0] f1_run_q, f1_run_d, f1_buf_q, f1_buf_d;
    logic [31:0] hi_run_q, hi_run_d, hi_buf_q, hi_buf_d;
    logic [31:0] lo_run_q, lo_run_d, lo_buf_q, lo_buf_d;
    logic        meas_vld_q, meas_vld_d;

    ph_state_e   ph_state_q, ph_state_d;
    logic [31:0] ph_cnt_q, ph_cnt_d;
    logic [31:0] ph_buf_q, ph_buf_d;
    logic        ph_vld_q, ph_vld_d;

    // Synchronizers shift toward the MSB; the MSB is the usable level.
    always_comb begin
        sync0_d = {sync0_q[SYNC_STAGES-2:0], sig_in0};
        sync1_d = {sync1_q[SYNC_STAGES-2:0], sig_in1};
        lvl0    = sync0_q[SYNC_STAGES-1];
        lvl1    = sync1_q[SYNC_STAGES-1];
        rise0   = lvl0 & ~dly0_q;
        rise1   = lvl1 & ~dly1_q;
    end

    // Window accounting: the closing cycle is included in the buffers, never in the next run.
    always_comb begin
        win_end    = (gate_cnt_q == GATE_LAST);
        gate_cnt_d = win_end ? 32'd0 : gate_cnt_q + 32'd1;

        f0_run_d   = sat_add1(f0_run_q, rise0);
        f1_run_d   = sat_add1(f1_run_q, rise1);
        hi_run_d   = sat_add1(hi_run_q, lvl0);
        lo_run_d   = sat_add1(lo_run_q, ~lvl0);

        f0_buf_d   = f0_buf_q;
        f1_buf_d   = f1_buf_q;
        hi_buf_d   = hi_buf_q;
        lo_buf_d   = lo_buf_q;
        meas_vld_d = win_end;

        if (win_end) begin
            f0_buf_d = f0_run_d;
            f1_buf_d = f1_run_d;
            hi_buf_d = hi_run_d;
            lo_buf_d = lo_run_d;
            f0_run_d = 32'd0;
            f1_run_d = 32'd0;
            hi_run_d = 32'd0;
            lo_run_d = 32'd0;
        end
    end

    // Phase FSM: a coincident rise0/rise1 always reports zero delay.
    always_comb begin
        ph_state_d = ph_state_q;
        ph_cnt_d   = ph_cnt_q;
        ph_buf_d   = ph_buf_q;
        ph_vld_d   = 1'b0;

        unique case (ph_state_q)
            PH_IDLE: begin
                if (rise0 && rise1) begin
                    ph_buf_d = 32'd0;
                    ph_vld_d = 1'b1;
                end else if (rise0) begin
                    ph_cnt_d   = 32'd0;
                    ph_state_d = PH_MEAS;
                end
            end
            PH_MEAS: begin
                if (rise0 && rise1) begin
                    ph_buf_d   = 32'd0;
                    ph_vld_d   = 1'b1;
                    ph_state_d = PH_IDLE;
                end else if (rise1) begin
                    ph_buf_d   = sat_add1(ph_cnt_q, 1'b1);
                    ph_vld_d   = 1'b1;
                    ph_state_d = PH_IDLE;
                end else if (rise0) begin
                    ph_cnt_d = 32'd0;
                end else begin
                    ph_cnt_d = sat_add1(ph_cnt_q, 1'b1);
                end
            end
            default: begin
                ph_state_d = PH_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync0_q    <= '0;
            sync1_q    <= '0;
            dly0_q     <= 1'b0;
            dly1_q     <= 1'b0;
            gate_cnt_q <= 32'd0;
            f0_run_q   <= 32'd0;
            f1_run_q   <= 32'd0;
            hi_run_q   <= 32'd0;
            lo_run_q   <= 32'd0;
            f0_buf_q   <= 32'd0;
            f1_buf_q   <= 32'd0;
            hi_buf_q   <= 32'd0;
            lo_buf_q   <= 32'd0;
            meas_vld_q <= 1'b0;
            ph_state_q <= PH_IDLE;
            ph_cnt_q   <= 32'd0;
            ph_buf_q   <= 32'd0;
            ph_vld_q   <= 1'b0;
        end else begin
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            dly0_q     <= lvl0;
            dly1_q     <= lvl1;
            gate_cnt_q <= gate_cnt_d;
            f0_run_q   <= f0_run_d;
            f1_run_q   <= f1_run_d;
            hi_run_q   <= hi_run_d;
            lo_run_q   <= lo_run_d;
            f0_buf_q   <= f0_buf_d;
            f1_buf_q   <= f1_buf_d;
            hi_buf_q   <= hi_buf_d;
            lo_buf_q   <= lo_buf_d;
            meas_vld_q <= meas_vld_d;
            ph_state_q <= ph_state_d;
            ph_cnt_q   <= ph_cnt_d;
            ph_buf_q   <= ph_buf_d;
            ph_vld_q   <= ph_vld_d;
        end
    end

    assign res_o.sig_freq_cnt_buf0   = f0_buf_q;
    assign res_o.sig_freq_cnt_buf1   = f1_buf_q;
    assign res_o.sig_in_high_cnt_buf = hi_buf_q;
    assign res_o.sig_in_low_cnt_buf  = lo_buf_q;
    assign res_o.meas_valid          = meas_vld_q;
    assign res_o.phase_diff_cnt_buf  = ph_buf_q;
    assign res_o.phase_valid         = ph_vld_q;

endmodule

// File: tb/tb_dual_signal_meter.sv
// Scoreboard bench for dual_signal_meter: a pin-history reference model queues expected
// window and phase results; a negedge monitor pops them whenever a valid strobe appears.
module tb_dual_signal_meter;
    localparam int G = 1000;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic sig_in0 = 1'b0;
    logic sig_in1 = 1'b0;

    dual_signal_meter_if mif();

    dual_signal_meter #(.GATE_CYCLES(G), .SYNC_STAGES(2)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .sig_in0 (sig_in0),
        .sig_in1 (sig_in1),
        .res_o   (mif)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] hi;
        logic [31:0] lo;
        longint      t;
    } win_t;

    typedef struct {
        logic [31:0] ph;
        longint      t;
    } ph_t;

    win_t   win_q[$];
    ph_t    ph_q[$];
    bit     p0h[$];
    bit     p1h[$];
    int     pend     = -1;
    bit     sat_mode = 1'b0;
    longint tick     = 0;
    logic   rst_edge = 1'b0;
    int     n_tests  = 0;
    int     n_fail   = 0;

    always @(posedge sys_clk) begin
        tick     <= tick + 1;
        rst_edge <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at tick %0d", name, act, exp, tick);
        end
    endtask

    // Synchronized level seen by the meter in cycle c (counted from reset release).
    function automatic bit lvl_at(input bit which, input int c);
        if (c < 2) return 1'b0;
        return which ? p1h[c-2] : p0h[c-2];
    endfunction

    function automatic bit rise_at(input bit which, input int c);
        return lvl_at(which, c) && !lvl_at(which, c - 1);
    endfunction

    task automatic step(input bit r, input bit a, input bit b);
        int n;
        int f0, f1, hi;
        bit r0, r1;
        @(posedge sys_clk);
        #1;
        rst     = r;
        sig_in0 = a;
        sig_in1 = b;
        if (r) begin
            p0h.delete();
            p1h.delete();
            pend = -1;
        end else begin
            n = p0h.size();
            p0h.push_back(a);
            p1h.push_back(b);
            r0 = rise_at(1'b0, n);
            r1 = rise_at(1'b1, n);
            if (r0 && r1) begin
                ph_q.push_back('{32'd0, tick + 1});
                pend = -1;
            end else if (r1 && pend >= 0) begin
                ph_q.push_back('{sat_mode ? 32'hFFFF_FFFF : 32'(n - pend), tick + 1});
                pend = -1;
            end else if (r0) begin
                pend = n;
            end
            if (n % G == G - 1) begin
                f0 = 0; f1 = 0; hi = 0;
                for (int c = n - G + 1; c <= n; c++) begin
                    f0 += int'(rise_at(1'b0, c));
                    f1 += int'(rise_at(1'b1, c));
                    hi += int'(lvl_at(1'b0, c));
                end
                win_q.push_back('{32'(f0), 32'(f1), 32'(hi), 32'(G - hi), tick + 1});
            end
        end
    endtask

    task automatic run(input int mode, input int k);
        bit a, b;
        for (int pc = 0; pc < k; pc++) begin
            case (mode)
                1: begin a = (pc % 10) < 5;  b = (pc % 20) < 10; end
                2: begin a = (pc % 10) < 3;  b = 1'($urandom_range(0, 1)); end
                3: begin a = (pc % 20) < 10; b = (pc >= 3) && (((pc - 3) % 20) < 10); end
                4: begin a = (pc % 20) < 10; b = (pc % 20) < 10; end
                5: begin a = 1'b0;           b = 1'($urandom_range(0, 1)); end
                6: begin a = 1'b1;           b = 1'b0; end
                7: begin a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); end
                default: begin a = 1'b0; b = 1'b0; end
            endcase
            step(1'b0, a, b);
        end
    endtask

    task automatic align();
        while (p0h.size() % G != 0) step(1'b0, 1'b0, 1'b0);
    endtask

    // Two windows fully in the new pattern; the buffers then hold the second one.
    task automatic run_clean(input int mode);
        align();
        run(mode, 2 * G + 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a result.
    initial begin
        win_t w;
        ph_t  p;
        forever begin
            @(negedge sys_clk);
            if (rst_edge) begin
                chk("rst_freq0", mif.sig_freq_cnt_buf0, 32'd0);
                chk("rst_freq1", mif.sig_freq_cnt_buf1, 32'd0);
                chk("rst_phase", mif.phase_diff_cnt_buf, 32'd0);
                chk("rst_high", mif.sig_in_high_cnt_buf, 32'd0);
                chk("rst_low", mif.sig_in_low_cnt_buf, 32'd0);
                chk("rst_strobes", {30'd0, mif.meas_valid, mif.phase_valid}, 32'd0);
            end
            if (mif.meas_valid === 1'b1) begin
                if (win_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL meas_unexpected: meas_valid=1 expected no window at tick %0d", tick);
                end else begin
                    w = win_q.pop_front();
                    chk("meas_time", 32'(tick), 32'(w.t));
                    chk("win_freq0", mif.sig_freq_cnt_buf0, w.f0);
                    chk("win_freq1", mif.sig_freq_cnt_buf1, w.f1);
                    chk("win_high", mif.sig_in_high_cnt_buf, w.hi);
                    chk("win_low", mif.sig_in_low_cnt_buf, w.lo);
                end
            end
            if (mif.phase_valid === 1'b1) begin
                if (ph_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL phase_unexpected: phase_valid=1 value 0x%08h expected none at tick %0d",
                             mif.phase_diff_cnt_buf, tick);
                end else begin
                    p = ph_q.pop_front();
                    chk("phase_time", 32'(tick), 32'(p.t));
                    chk("phase_value", mif.phase_diff_cnt_buf, p.ph);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, 1'b0);

        run_clean(1);
        chk("A_freq0", mif.sig_freq_cnt_buf0, 32'd100);
        chk("A_freq1", mif.sig_freq_cnt_buf1, 32'd50);
        chk("A_high", mif.sig_in_high_cnt_buf, 32'd500);
        chk("A_low", mif.sig_in_low_cnt_buf, 32'd500);

        run_clean(2);
        chk("B_freq0", mif.sig_freq_cnt_buf0, 32'd100);
        chk("B_high", mif.sig_in_high_cnt_buf, 32'd300);
        chk("B_low", mif.sig_in_low_cnt_buf, 32'd700);

        run(3, 200);
        chk("phase_d3", mif.phase_diff_cnt_buf, 32'd3);
        run(4, 200);
        chk("phase_d0", mif.phase_diff_cnt_buf, 32'd0);
        run(5, 300);
        chk("phase_hold", mif.phase_diff_cnt_buf, 32'd0);

        run_clean(6);
        chk("K_freq0", mif.sig_freq_cnt_buf0, 32'd0);
        chk("K_freq1", mif.sig_freq_cnt_buf1, 32'd0);
        chk("K_high", mif.sig_in_high_cnt_buf, 32'd1000);
        chk("K_low", mif.sig_in_low_cnt_buf, 32'd0);

        run(7, 2500);

        align();
        run(7, 400);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        run(7, 1100);

        run(0, 30);
        sat_mode = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b0);
        run(0, 6);
        force dut.ph_cnt_q = 32'hFFFF_FFFE;
        @(negedge sys_clk);
        release dut.ph_cnt_q;
        run(0, 20);
        chk("ph_cnt_sat", dut.ph_cnt_q, 32'hFFFF_FFFF);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        run(0, 6);
        sat_mode = 1'b0;
        chk("phase_sat", mif.phase_diff_cnt_buf, 32'hFFFF_FFFF);

        run(0, 5);
        chk("win_q_drained", 32'(win_q.size()), 32'd0);
        chk("ph_q_drained", 32'(ph_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
